// File: rtl/mem_ctrl_pkg.sv
// Shared encodings, request payload and helpers for the IF/MEM memory responder.
package mem_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 3;

    localparam logic RST_ENABLE = 1'b0;

    localparam logic [1:0] IOM_NONE = 2'b00;
    localparam logic [1:0] IOM_IF   = 2'b01;
    localparam logic [1:0] IOM_MEM  = 2'b10;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;

    // Transfer latched at acceptance and held for its whole duration.
    typedef struct packed {
        logic              is_if;
        logic              sign;
        logic [CNT_W-1:0]  nbytes;
        logic [DATA_W-1:0] base;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Byte count for a MEM width code; the reserved code 11 moves a word.
    function automatic logic [CNT_W-1:0] width_bytes(input logic [1:0] w);
        case (w)
            WIDTH_BYTE: return CNT_W'(1);
            WIDTH_HALF: return CNT_W'(2);
            default:    return CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto a byte-wide registered RAM port.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_request,
    input  logic [DATA_W-1:0]         if_addr,
    input  logic                      mem_request,
    input  logic                      mem_we,
    input  logic [1:0]                mem_width,
    input  logic                      mem_sign,
    input  logic [DATA_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_wdata,
    output logic                      busy_mem_ctrl,
    output logic [1:0]                if_or_mem_o,
    output logic [DATA_W-1:0]         mcl_instr,
    output logic [DATA_W-1:0]         pc_back,
    output logic [DATA_W-1:0]         mcl_data,
    output logic [RAM_ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]                mem_dout,
    output logic                      mem_wr,
    input  logic [7:0]                mem_din
);

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    req_t                      req_q, req_d;
    logic [DATA_W-1:0]         rd_q, rd_d;
    logic                      busy_q, busy_d;
    logic [1:0]                iom_q, iom_d;
    logic [DATA_W-1:0]         instr_q, instr_d;
    logic [DATA_W-1:0]         pc_q, pc_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic [RAM_ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]                dout_q, dout_d;
    logic                      wr_q, wr_d;

    logic [CNT_W-1:0]          k;
    logic [4:0]                rd_sh;
    logic [4:0]                wr_sh;
    logic [DATA_W-1:0]         asm_word;

    // Next-state and output decode; k counts edges since the request was accepted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        rd_d     = rd_q;
        busy_d   = busy_q;
        iom_d    = IOM_NONE;
        instr_d  = instr_q;
        pc_d     = pc_q;
        data_d   = data_q;
        mem_a_d  = mem_a_q;
        dout_d   = dout_q;
        wr_d     = 1'b0;
        k        = cnt_q + CNT_W'(1);
        rd_sh    = {2'(k[1:0] - 2'd2), 3'b000};
        wr_sh    = {k[1:0], 3'b000};
        asm_word = rd_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (mem_request) begin
                    req_d.is_if  = 1'b0;
                    req_d.sign   = mem_sign;
                    req_d.nbytes = width_bytes(mem_width);
                    req_d.base   = mem_addr;
                    req_d.wdata  = mem_wdata;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    mem_a_d      = RAM_ADDR_WIDTH'(mem_addr);
                    if (mem_we) begin
                        dout_d  = mem_wdata[7:0];
                        wr_d    = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else if (if_request) begin
                    req_d.is_if  = 1'b1;
                    req_d.sign   = 1'b0;
                    req_d.nbytes = CNT_W'(4);
                    req_d.base   = if_addr;
                    req_d.wdata  = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    mem_a_d      = RAM_ADDR_WIDTH'(if_addr);
                    state_d      = ST_READ;
                end
            end

            ST_READ: begin
                cnt_d = k;
                if (k < req_q.nbytes) begin
                    mem_a_d = RAM_ADDR_WIDTH'(req_q.base + DATA_W'(k));
                end
                // RAM data lags the address by two edges, so lane k-2 arrives now.
                if (k >= CNT_W'(2)) begin
                    asm_word[rd_sh +: 8] = mem_din;
                end
                rd_d = asm_word;
                if (k == req_q.nbytes + CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (req_q.is_if) begin
                        instr_d = asm_word;
                        pc_d    = req_q.base + DATA_W'(4);
                        iom_d   = IOM_IF;
                    end else begin
                        case (req_q.nbytes)
                            CNT_W'(1): data_d = {{24{req_q.sign & asm_word[7]}}, asm_word[7:0]};
                            CNT_W'(2): data_d = {{16{req_q.sign & asm_word[15]}}, asm_word[15:0]};
                            default:   data_d = asm_word;
                        endcase
                        iom_d = IOM_MEM;
                    end
                end
            end

            ST_WRITE: begin
                cnt_d = k;
                if (k < req_q.nbytes) begin
                    mem_a_d = RAM_ADDR_WIDTH'(req_q.base + DATA_W'(k));
                    dout_d  = req_q.wdata[wr_sh +: 8];
                    wr_d    = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    iom_d   = IOM_MEM;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            iom_q   <= IOM_NONE;
            instr_q <= '0;
            pc_q    <= '0;
            data_q  <= '0;
            mem_a_q <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            iom_q   <= iom_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            mem_a_q <= mem_a_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
        end
    end

    assign busy_mem_ctrl = busy_q;
    assign if_or_mem_o   = iom_q;
    assign mcl_instr     = instr_q;
    assign pc_back       = pc_q;
    assign mcl_data      = data_q;
    assign mem_a         = mem_a_q;
    assign mem_dout      = dout_q;
    assign mem_wr        = wr_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory-side responder for the IF and MEM stages. It arbitrates single outstanding requests from IF (instruction fetch) and MEM (load/store) onto one byte-wide synchronous RAM port. It assembles or splits 1/2/4-byte little-endian transfers and returns results with busy / if_or_mem handshaking. IF treats mcl_instr and pc_back as valid when busy=0 and if_or_mem=01.

Parameters:
RAM_ADDR_WIDTH, 32, width of mem_a driven to RAM (low bits of byte address)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
if_request  in  1  1 = IF requests 4-byte instruction read
if_addr  in  32  IF byte address
mem_request  in  1  1 = MEM requests load/store; held until served
mem_we  in  1  0 load, 1 store
mem_width  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_sign  in  1  loads: 1 sign-extend, 0 zero-extend
mem_addr  in  32  MEM byte address
mem_wdata  in  32  store data, low bytes used
busy_mem_ctrl  out  1  1 while a transfer is in progress
if_or_mem_o  out  2  00 none, 01 result for IF, 10 result/ack for MEM; valid for one cycle
mcl_instr  out  32  fetched instruction
pc_back  out  32  latched if_addr + 4, mod 2^32
mcl_data  out  32  load result, extended
mem_a  out  RAM_ADDR_WIDTH  RAM byte address
mem_dout  out  8  RAM write byte
mem_wr  out  1  1 = RAM write this cycle
mem_din  in  8  RAM read byte; registered RAM, data for address driven at edge e is sampled by this block at edge e+2

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; every output 0, including busy, if_or_mem_o, mcl_instr, pc_back, mcl_data, mem_a, mem_dout and mem_wr. A reset mid-transfer aborts it. No result pulse is produced, and mem_wr drops the same edge.
- States: IDLE, READ, WRITE.
- IDLE, at edge t:
  - Arbitration: mem_request wins over if_request; IF stays pending.
  - Latch kind, base address, byte count N (1/2/4; IF always 4), wdata, sign.
  - Set cnt=0, busy=1, if_or_mem_o=00.
  - Read: mem_a=base, mem_wr=0, go READ.
  - Write: mem_a=base, mem_dout=wdata[7:0], mem_wr=1, go WRITE.
  - No request: busy=0, if_or_mem_o=00, mem_wr=0.
- READ:
  - Byte i is addressed at edge t+i (mem_a=base+i, 32-bit wrap, truncated to RAM_ADDR_WIDTH) and captured from mem_din at edge t+i+2 into byte lane i.
  - At edge t+N+1: last byte captured; busy=0; state=IDLE.
  - IF: mcl_instr={b3,b2,b1,b0}, pc_back=base+4, if_or_mem_o=01.
  - MEM: mcl_data=extended value, if_or_mem_o=10. Byte extends from bit 7, half from bit 15.
  - Read latency N+1 edges after acceptance (word: 5).
- WRITE:
  - Byte i is driven at edge t+i (mem_a=base+i, mem_dout=wdata[8i+7:8i], mem_wr=1).
  - At edge t+N: mem_wr=0, busy=0, if_or_mem_o=10, state=IDLE.
- if_or_mem_o is nonzero for exactly one cycle; it returns to 00 at the next edge. mcl_instr, pc_back and mcl_data hold their values until overwritten.
- The edge after a result may accept a new request (back-to-back allowed).
- Requests arriving while busy are ignored and not queued. Requesters hold their request lines.
- mem_request and if_request both high in IDLE: MEM served first, IF served in the next IDLE.
- mem_a between transfers holds its last value; mem_wr is 0 outside WRITE.

Decomposition:
- Shared defines header (existing): RstEnable = 1'b0; if_or_mem encodings 00/01/10; width encodings 00/01/10; state encodings IDLE/READ/WRITE.
- Single module, no sub-module. The load-extension mux stays inline.

Test Plan:
- Fetch at if_addr=0x1000, RAM bytes 13 05 00 00 → at edge t+5: busy=0, if_or_mem_o=01, mcl_instr=0x00000513, pc_back=0x00001004. mem_a sequence 0x1000..0x1003 with mem_wr=0.
- Signed byte load at 0x20, RAM=0x80 → mcl_data=0xFFFFFF80, if_or_mem_o=10 at t+2. Repeat with mem_sign=0 → 0x00000080.
- Unsigned half load at 0x40, RAM 0x34 0x92 → mcl_data=0x00009234 at t+3.
- Store word 0xDEADBEEF at 0x100 → mem_wr=1 on edges t..t+3 with (0x100,EF), (0x101,BE), (0x102,AD), (0x103,DE); at t+4 mem_wr=0, if_or_mem_o=10.
- if_request and mem_request (store byte 0x5A at 0x8) asserted together → store completes first; IF fetch is accepted on the next edge after the MEM ack and completes 5 edges later.
- Reset (rst=0) at edge t+2 of a word fetch → all outputs 0, no if_or_mem_o pulse. After rst=1, a fresh fetch completes normally.
